alu_mul_sequencer: RTL and testbench

- Multi-cycle 16-bit multiplier controller that sits directly upstream of the ALU.
- Drives the ALU operand/opcode inputs from its own registers and captures the ALU result/flags back each cycle.
- Computes the low 16 bits of a*b, MSB-first, using only ALU ADD (M+N+C) operations: doubling plus conditional add.
- Valid/ready handshake on both command and result sides.

---
 rtl/alu_mul_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
// Multi-cycle 16-bit multiplier controller placed upstream of a combinational
// ALU. The product's low 16 bits are built MSB-first from ALU ADD operations
// only: every multiplier bit doubles the accumulator (acc+acc), and every set
// bit adds the multiplicand (acc+a). All sums wrap mod 2^16.
//
// Build option: MUL_EARLY_EXIT_EN
//   undefined : fixed BITS-step walk, latency BITS + popcount(b).
//   defined   : the walk starts at the highest set bit of b, and b==0
//               finishes on the accept edge with a zero product.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a command, ALU held on the side-effect-free opcode
// DBL   | acc <= acc + acc for multiplier bit idx
// ADD   | acc <= acc + a_r, because multiplier bit idx is set
// DONE  | product and flags held until the result handshake
module alu_mul_sequencer #(
  parameter int          BITS     = 16,
  parameter logic [2:0]  IDLE_OPC = 3'b100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        out_zer,
  output logic        out_neg,
  output logic [15:0] alu_n,
  output logic [15:0] alu_m,
  output logic        alu_c,
  output logic [2:0]  alu_opc,
  input  logic [15:0] alu_f,
  input  logic        alu_zer,
  input  logic        alu_neg
);

  localparam logic [2:0]  OPC_ADD  = 3'b000;
  localparam logic [3:0]  IDX_TOP  = 4'(BITS - 1);
  localparam logic [15:0] B_MASK   = 16'((17'h1 << BITS) - 17'h1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DBL  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [15:0] acc;
  logic [3:0]  idx;

  logic        accept;
  logic        idx_zero;
  logic        cur_bit;
  logic [15:0] b_in_m;
  logic [3:0]  idx_load;

  assign accept   = in_valid && (state == S_IDLE);
  assign idx_zero = (idx == 4'd0);
  assign cur_bit  = b_r[idx];
  assign b_in_m   = in_b & B_MASK;
  assign out_p    = acc;

`ifdef MUL_EARLY_EXIT_EN
  // Index of the highest set bit among the multiplier bits that are walked.
  function automatic logic [3:0] msb_index(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < BITS; i++) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // A zero multiplier skips the walk entirely.
  logic b_in_zero;
  assign b_in_zero = (b_in_m == 16'h0000);
  assign idx_load  = msb_index(b_in_m);
`else
  assign idx_load  = IDX_TOP;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
`ifdef MUL_EARLY_EXIT_EN
          state_nx = b_in_zero ? S_DONE : S_DBL;
`else
          state_nx = S_DBL;
`endif
        end
      end
      S_DBL: begin
        if (cur_bit) begin
          state_nx = S_ADD;
        end else if (idx_zero) begin
          state_nx = S_DONE;
        end
      end
      S_ADD: begin
        state_nx = idx_zero ? S_DONE : S_DBL;
      end
      S_DONE: begin
        if (out_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake outputs and ALU operand/opcode drive.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    alu_opc   = IDLE_OPC;
    alu_m     = 16'h0000;
    alu_n     = 16'h0000;
    alu_c     = 1'b0;
    case (state)
      S_DBL: begin
        alu_opc = OPC_ADD;
        alu_m   = acc;
        alu_n   = acc;
      end
      S_ADD: begin
        alu_opc = OPC_ADD;
        alu_m   = acc;
        alu_n   = a_r;
      end
      default: ;
    endcase
  end

  // Operand capture, accumulator/flag write-back from the ALU, bit index walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= 16'h0000;
      b_r     <= 16'h0000;
      acc     <= 16'h0000;
      idx     <= 4'd0;
      out_zer <= 1'b0;
      out_neg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_r <= in_a;
            b_r <= b_in_m;
            acc <= 16'h0000;
            idx <= idx_load;
`ifdef MUL_EARLY_EXIT_EN
            if (b_in_zero) begin
              out_zer <= 1'b1;
              out_neg <= 1'b0;
            end
`endif
          end
        end
        S_DBL: begin
          acc     <= alu_f;
          out_zer <= alu_zer;
          out_neg <= alu_neg;
          if (!cur_bit && !idx_zero) begin
            idx <= idx - 4'd1;
          end
        end
        S_ADD: begin
          acc     <= alu_f;
          out_zer <= alu_zer;
          out_neg <= alu_neg;
          if (!idx_zero) begin
            idx <= idx - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer
// Directed and randomized bench for alu_mul_sequencer with a behavioural ALU.
// Expected products come from plain multiplication, expected latency from the
// popcount/top-bit of the multiplier. Honours MUL_EARLY_EXIT_EN like the DUT.
module tb_alu_mul_sequencer;

  localparam int         BITS     = 16;
  localparam logic [2:0] IDLE_OPC = 3'b100;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        out_zer;
  logic        out_neg;
  logic [15:0] alu_n;
  logic [15:0] alu_m;
  logic        alu_c;
  logic [2:0]  alu_opc;
  logic [15:0] alu_f;
  logic        alu_zer;
  logic        alu_neg;

  int checks = 0;
  int fails  = 0;

  alu_mul_sequencer #(.BITS(BITS), .IDLE_OPC(IDLE_OPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_zer   (out_zer),
    .out_neg   (out_neg),
    .alu_n     (alu_n),
    .alu_m     (alu_m),
    .alu_c     (alu_c),
    .alu_opc   (alu_opc),
    .alu_f     (alu_f),
    .alu_zer   (alu_zer),
    .alu_neg   (alu_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU: ADD, AND, and XOR for anything else.
  always_comb begin
    case (alu_opc)
      3'b000:  alu_f = alu_m + alu_n + {15'h0, alu_c};
      3'b100:  alu_f = alu_m & alu_n;
      default: alu_f = alu_m ^ alu_n;
    endcase
    alu_zer = (alu_f == 16'h0000);
    alu_neg = alu_f[15];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_product(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] full;
    full = 32'(a) * 32'(b & 16'((17'h1 << BITS) - 17'h1));
    return full[15:0];
  endfunction

  function automatic int model_latency(input logic [15:0] b);
    int pop;
    int top;
    pop = 0;
    top = -1;
    for (int i = 0; i < BITS; i++) begin
      if (b[i]) begin
        pop++;
        top = i;
      end
    end
`ifdef MUL_EARLY_EXIT_EN
    // A zero multiplier is already DONE right after the accept edge.
    return (top < 0) ? 0 : (top + 1 + pop);
`else
    return BITS + pop;
`endif
  endfunction

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits for out_valid after an accept edge and checks result, flags, latency.
  task automatic wait_result(input logic [15:0] a, input logic [15:0] b, input string tag);
    int          lat;
    logic        bad_opc;
    logic        bad_mn;
    logic [15:0] p;
    lat     = 0;
    bad_opc = 1'b0;
    bad_mn  = 1'b0;
    p       = model_product(a, b);
    while (!out_valid && lat < 200) begin
      if (alu_opc !== 3'b000 || alu_c !== 1'b0) bad_opc = 1'b1;
      if (b == 16'h0000 && (alu_m !== 16'h0 || alu_n !== 16'h0)) bad_mn = 1'b1;
      if (in_ready !== 1'b0) bad_opc = 1'b1;
      step();
      lat++;
    end
    check({tag, "_valid"},   32'(out_valid), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(model_latency(b)));
    check({tag, "_p"},       32'(out_p), 32'(p));
    check({tag, "_zer"},     32'(out_zer), 32'(p == 16'h0000));
    check({tag, "_neg"},     32'(out_neg), 32'(p[15]));
    check({tag, "_busy_drive"}, 32'(bad_opc), 32'd0);
    if (b == 16'h0000) check({tag, "_zero_operands"}, 32'(bad_mn), 32'd0);
    check({tag, "_done_opc"}, 32'(alu_opc), 32'(IDLE_OPC));
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input string tag);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom();
    in_b     = $urandom();
    wait_result(a, b, tag);
  endtask

  // Holds out_ready low, confirming the result and flags stay put.
  task automatic hold(input int n, input string tag);
    logic [15:0] p0;
    logic        z0;
    logic        n0;
    logic        bad;
    p0  = out_p;
    z0  = out_zer;
    n0  = out_neg;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_p !== p0 ||
          out_zer !== z0 || out_neg !== n0) bad = 1'b1;
    end
    check({tag, "_hold_stable"}, 32'(bad), 32'd0);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_after_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_after_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    out_ready = 1'b0;
    #23;
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_p",     32'(out_p), 32'd0);
    check("rst_flags",     32'({out_zer, out_neg}), 32'd0);
    check("rst_alu_opc",   32'(alu_opc), 32'(IDLE_OPC));
    check("rst_alu_mnc",   32'({alu_m, alu_n, alu_c}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // out_ready while idle must do nothing.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_ready_noeffect", 32'({out_valid, in_ready}), 32'b01);

    issue(16'd3, 16'd5, "a3b5");
    consume("a3b5");
    issue(16'hFFFE, 16'd7, "neg");
    consume("neg");
    issue(16'h0100, 16'h0100, "wrap");
    consume("wrap");
    issue(16'h1234, 16'h0000, "bzero");
    consume("bzero");
    issue(16'hFFFF, 16'hFFFF, "allones");
    consume("allones");

    // Backpressure with a second command waiting during DONE.
    issue(16'd11, 16'd13, "bp1");
    in_valid = 1'b1;
    in_a     = 16'd21;
    in_b     = 16'd4;
    hold(5, "bp1");
    check("bp1_p_held", 32'(out_p), 32'd143);
    consume("bp1");
    issue(16'd21, 16'd4, "bp2");
    consume("bp2");

    // Reset pulse in the middle of a long operation.
    in_valid = 1'b1;
    in_a     = 16'd9;
    in_b     = 16'hFFFF;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_opc",   32'(alu_opc), 32'(IDLE_OPC));
    step();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_opc !== IDLE_OPC) seen = 1'b1;
      step();
    end
    check("midrst_quiet", 32'(seen), 32'd0);
    issue(16'd2, 16'd3, "postrst");
    consume("postrst");

    // Randomized commands with random result backpressure.
    for (int k = 0; k < 24; k++) begin
      ra = 16'($urandom());
      case ($urandom_range(0, 3))
        0:       rb = 16'h0001 << $urandom_range(0, 15);
        1:       rb = 16'h0000;
        default: rb = 16'($urandom());
      endcase
      issue(ra, rb, "rand");
      hold(int'($urandom_range(0, 3)), "rand");
      consume("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
